// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and width constants for the sequential divider
package div_pkg;
  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  function automatic int cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction
  localparam int CW_DEF = cnt_w(DW_DEF);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/div_16x8_seq_if.sv
// div_16x8_seq_if: operand/result valid-ready bus of the sequential divider
interface div_16x8_seq_if import div_pkg::*; #(parameter int DW = DW_DEF, parameter int VW = VW_DEF);
  logic in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [DW-1:0] dividend, quotient;
  logic [VW-1:0] divisor, remainder;
  modport slave (
    input in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step
module div_step import div_pkg::*; #(parameter int VW = VW_DEF) (
  input  logic [VW:0]   pr,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_nxt,
  output logic          q_bit
);
  logic [VW:0] t;
  always_comb begin
    t = {pr[VW-1:0], bit_in};
    // a set pr MSB means the shifted value exceeds VW+1 bits and always fits the divisor
    q_bit = pr[VW] | (t >= {1'b0, divisor});
    pr_nxt = q_bit ? t - {1'b0, divisor} : t;
  end
endmodule

// File: rtl/div_16x8_seq.sv
// div_16x8_seq: restoring divider retiring one quotient bit per clock behind valid/ready
module div_16x8_seq import div_pkg::*; #(parameter int DW = DW_DEF, parameter int VW = VW_DEF) (
  input logic clk,
  input logic rst_n,
  div_16x8_seq_if.slave bus
);
  localparam int CW = cnt_w(DW);
  state_t state, state_nxt;
  logic [DW-1:0] q;
  logic [VW-1:0] dvs, rem;
  logic [VW:0] pr, pr_nxt;
  logic [CW-1:0] cnt;
  logic dz, q_bit, accept, last, zero;
  assign accept = bus.in_valid & bus.in_ready;
  assign last = cnt == CW'(DW - 1);
  assign zero = bus.divisor == '0;
  div_step #(.VW(VW)) u_step (
    .pr(pr),
    .bit_in(q[DW-1]),
    .divisor(dvs),
    .pr_nxt(pr_nxt),
    .q_bit(q_bit)
  );
  always_comb begin
    state_nxt = state;
    if (state == IDLE && accept) state_nxt = zero ? DONE : BUSY;
    if (state == BUSY && last) state_nxt = DONE;
    if (state == DONE && bus.out_ready) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      dvs <= '0;
      pr <= '0;
      cnt <= '0;
      rem <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        q <= zero ? '1 : bus.dividend;
        dvs <= bus.divisor;
        pr <= '0;
        cnt <= '0;
        rem <= zero ? bus.dividend[VW-1:0] : '0;
        dz <= zero;
      end else if (state == BUSY) begin
        q <= {q[DW-2:0], q_bit};
        pr <= pr_nxt;
        cnt <= cnt + CW'(1);
        if (last) rem <= pr_nxt[VW-1:0];
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.quotient = q;
  assign bus.remainder = rem;
  assign bus.div_by_zero = dz;
endmodule
